// File: rtl/crc_req_scheduler_if.sv
// Bundle between crc_req_scheduler, its two requesters, the CRC datapath and the response consumer.
// master = scheduler side, slave = environment (requesters, datapath, consumer).
interface crc_req_scheduler_if #(
    parameter int N = 11,
    parameter int M = 5
);
    logic         req_valid_0;
    logic [N-1:0] req_data_0;
    logic [M-1:0] req_poly_0;
    logic         req_errinj_0;
    logic         req_ready_0;

    logic         req_valid_1;
    logic [N-1:0] req_data_1;
    logic [M-1:0] req_poly_1;
    logic         req_errinj_1;
    logic         req_ready_1;

    logic [N-1:0] dp_data;
    logic [M-1:0] dp_poly;
    logic         dp_err_en;
    logic         dp_start;
    logic [N-1:0] dp_data_out;
    logic         dp_error_check;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_data;
    logic         rsp_err;

    modport master (
        input  req_valid_0, req_data_0, req_poly_0, req_errinj_0,
        output req_ready_0,
        input  req_valid_1, req_data_1, req_poly_1, req_errinj_1,
        output req_ready_1,
        output dp_data, dp_poly, dp_err_en, dp_start,
        input  dp_data_out, dp_error_check,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output req_valid_0, req_data_0, req_poly_0, req_errinj_0,
        input  req_ready_0,
        output req_valid_1, req_data_1, req_poly_1, req_errinj_1,
        input  req_ready_1,
        input  dp_data, dp_poly, dp_err_en, dp_start,
        output dp_data_out, dp_error_check,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/crc_req_scheduler.sv
// Two-requester round-robin front end for a shared fixed-latency CRC datapath, one transaction in flight.
// Optional per-requester saturating error counters when CRC_SCHED_STATS_EN is defined.
module crc_req_scheduler #(
    parameter int N      = 11,
    parameter int M      = 5,
    parameter int DP_LAT = 3     // legal range 1..15
) (
    input  logic                  Clk,
    input  logic                  reset,
    crc_req_scheduler_if.master   bus
`ifdef CRC_SCHED_STATS_EN
    ,
    output logic [7:0]            err_cnt_0,
    output logic [7:0]            err_cnt_1
`endif
);

    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DP_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          req_valid;
    logic [1:0][N-1:0]   req_data;
    logic [1:0][M-1:0]   req_poly;
    logic [1:0]          req_errinj;

    assign req_valid  = {bus.req_valid_1,  bus.req_valid_0};
    assign req_data   = {bus.req_data_1,   bus.req_data_0};
    assign req_poly   = {bus.req_poly_1,   bus.req_poly_0};
    assign req_errinj = {bus.req_errinj_1, bus.req_errinj_0};

    logic [1:0]       state_q,     state_d;
    logic             rr_ptr_q,    rr_ptr_d;
    logic             id_q,        id_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [N-1:0]     dp_data_q,   dp_data_d;
    logic [M-1:0]     dp_poly_q,   dp_poly_d;
    logic             dp_err_en_q, dp_err_en_d;
    logic             dp_start_q,  dp_start_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q,    rsp_id_d;
    logic [N-1:0]     rsp_data_q,  rsp_data_d;
    logic             rsp_err_q,   rsp_err_d;

    logic win_id;
    logic accept;
    logic rsp_hs;

    // A lone requester always wins; contention is settled by the round-robin pointer.
    always_comb begin
        win_id = req_valid[1];
        if (&req_valid) win_id = rr_ptr_q;
    end

    assign accept          = (state_q == S_IDLE) && (|req_valid);
    assign bus.req_ready_0 = accept && !win_id;
    assign bus.req_ready_1 = accept &&  win_id;
    assign rsp_hs          = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        dp_data_d   = dp_data_q;
        dp_poly_d   = dp_poly_q;
        dp_err_en_d = dp_err_en_q;
        dp_start_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dp_data_d   = req_data[win_id];
                    dp_poly_d   = req_poly[win_id];
                    dp_err_en_d = req_errinj[win_id];
                    id_d        = win_id;
                    dp_start_d  = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cnt reaching zero lines up with the datapath output settling DP_LAT cycles after issue
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = bus.dp_data_out;
                    rsp_err_d   = bus.dp_error_check;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = ~id_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            dp_data_q   <= '0;
            dp_poly_q   <= '0;
            dp_err_en_q <= 1'b0;
            dp_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            dp_data_q   <= dp_data_d;
            dp_poly_q   <= dp_poly_d;
            dp_err_en_q <= dp_err_en_d;
            dp_start_q  <= dp_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.dp_data   = dp_data_q;
    assign bus.dp_poly   = dp_poly_q;
    assign bus.dp_err_en = dp_err_en_q;
    assign bus.dp_start  = dp_start_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef CRC_SCHED_STATS_EN
    logic [1:0][7:0] err_cnt_q;

    for (genvar g = 0; g < 2; g++) begin : g_stats
        logic bump;
        assign bump = rsp_hs && rsp_err_q && (rsp_id_q == 1'(g));
        always_ff @(posedge Clk or negedge reset) begin
            if (!reset)                          err_cnt_q[g] <= '0;
            else if (bump && err_cnt_q[g] != '1) err_cnt_q[g] <= err_cnt_q[g] + 8'd1;
        end
    end

    assign err_cnt_0 = err_cnt_q[0];
    assign err_cnt_1 = err_cnt_q[1];
`endif

endmodule

// File: tb/tb_crc_req_scheduler.sv
// Directed bench for crc_req_scheduler with a DP_LAT-deep pass-through datapath model.
module tb_crc_req_scheduler;
    localparam int N      = 11;
    localparam int M      = 5;
    localparam int DP_LAT = 3;

    logic Clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    crc_req_scheduler_if #(.N(N), .M(M)) bus ();
`ifdef CRC_SCHED_STATS_EN
    logic [7:0] err_cnt_0, err_cnt_1;
`endif

    crc_req_scheduler #(.N(N), .M(M), .DP_LAT(DP_LAT)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
`ifdef CRC_SCHED_STATS_EN
        ,
        .err_cnt_0 (err_cnt_0),
        .err_cnt_1 (err_cnt_1)
`endif
    );

    always #5 Clk = ~Clk;

    // Datapath stand-in: data passes through, error_check follows error_enable, DP_LAT cycles late.
    logic [DP_LAT-1:0][N:0] dp_pipe = '0;
    always_ff @(posedge Clk) dp_pipe <= {dp_pipe[DP_LAT-2:0], {bus.dp_err_en, bus.dp_data}};
    assign bus.dp_data_out    = dp_pipe[DP_LAT-1][N-1:0];
    assign bus.dp_error_check = dp_pipe[DP_LAT-1][N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 20), 32'd1);
    endtask

    initial begin
        int         n, ng, nr, both, hs;
        logic       ok, seen;
        logic [4:0] gseq, rseq;

        bus.req_valid_0 = 0; bus.req_data_0 = '0; bus.req_poly_0 = '0; bus.req_errinj_0 = 0;
        bus.req_valid_1 = 0; bus.req_data_1 = '0; bus.req_poly_1 = '0; bus.req_errinj_1 = 0;
        bus.rsp_ready   = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_dp_start",  32'(bus.dp_start),  32'd0);
        chk("rst_dp_data",   32'(bus.dp_data),   32'd0);
        chk("rst_dp_err_en", 32'(bus.dp_err_en), 32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
`ifdef CRC_SCHED_STATS_EN
        chk("rst_err_cnt_0", 32'(err_cnt_0), 32'd0);
        chk("rst_err_cnt_1", 32'(err_cnt_1), 32'd0);
`endif
        reset = 1;
        tick();

        // Single request from requester 0, latency accept+5
        bus.req_valid_0 = 1; bus.req_data_0 = 11'h5A3; bus.req_poly_0 = 5'b10011; bus.req_errinj_0 = 0;
        bus.rsp_ready = 1;
        #1;
        chk("t1_ready0", 32'(bus.req_ready_0), 32'd1);
        chk("t1_ready1", 32'(bus.req_ready_1), 32'd0);
        tick(); bus.req_valid_0 = 0; #1;
        chk("t1_ready0_drop", 32'(bus.req_ready_0), 32'd0);
        chk("t1_dp_start",    32'(bus.dp_start),    32'd1);
        chk("t1_dp_data",     32'(bus.dp_data),     32'h5A3);
        chk("t1_dp_poly",     32'(bus.dp_poly),     32'h13);
        chk("t1_dp_err_en",   32'(bus.dp_err_en),   32'd0);
        tick();
        chk("t1_dp_start_off", 32'(bus.dp_start), 32'd0);
        tick(); tick();
        chk("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("t1_rsp_data",  32'(bus.rsp_data),  32'h5A3);
        chk("t1_rsp_err",   32'(bus.rsp_err),   32'd0);
        tick();
        chk("t1_rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("t1_dp_hold",  32'(bus.dp_data),   32'h5A3);

        // Response back-pressure; requester 1 waits with an error-injection request
        bus.rsp_ready = 0;
        bus.req_valid_0 = 1; bus.req_data_0 = 11'h3C5; bus.req_poly_0 = 5'b10101;
        #1;
        chk("t3_ready0", 32'(bus.req_ready_0), 32'd1);
        tick(); bus.req_valid_0 = 0;
        wait_rsp("t3_rsp_timeout");
        bus.req_valid_1 = 1; bus.req_data_1 = 11'h0FF; bus.req_poly_1 = 5'b10011; bus.req_errinj_1 = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", 32'(bus.rsp_valid),   32'd1);
            chk("t3_hold_data",  32'(bus.rsp_data),    32'h3C5);
            chk("t3_hold_err",   32'(bus.rsp_err),     32'd0);
            chk("t3_no_ready0",  32'(bus.req_ready_0), 32'd0);
            chk("t3_no_ready1",  32'(bus.req_ready_1), 32'd0);
            tick();
        end
        bus.rsp_ready = 1;
        tick(); #1;
        chk("t3_rsp_done", 32'(bus.rsp_valid),   32'd0);
        chk("t4_ready1",   32'(bus.req_ready_1), 32'd1);
        tick(); bus.req_valid_1 = 0; #1;
        chk("t4_dp_start",  32'(bus.dp_start),  32'd1);
        chk("t4_dp_data",   32'(bus.dp_data),   32'h0FF);
        n = 0; ok = 1;
        while (!bus.rsp_valid && n < 20) begin
            if (!bus.dp_err_en) ok = 0;
            tick();
            n++;
        end
        chk("t4_rsp_timeout", 32'(n < 20), 32'd1);
        chk("t4_err_en_held", 32'(ok),           32'd1);
        chk("t4_rsp_err",     32'(bus.rsp_err),  32'd1);
        chk("t4_rsp_id",      32'(bus.rsp_id),   32'd1);
        chk("t4_rsp_data",    32'(bus.rsp_data), 32'h0FF);
        tick();
        chk("t4_rsp_done", 32'(bus.rsp_valid), 32'd0);

        // Both requesters held valid: grants 0,1,0,1,0
        bus.req_valid_0 = 1; bus.req_data_0 = 11'h111; bus.req_errinj_0 = 0;
        bus.req_valid_1 = 1; bus.req_data_1 = 11'h222; bus.req_errinj_1 = 0;
        ng = 0; nr = 0; both = 0; ok = 1; gseq = '0; rseq = '0;
        for (int c = 0; c < 80 && nr < 5; c++) begin
            #1;
            if (bus.req_ready_0 && bus.req_ready_1) both++;
            if ((bus.req_ready_0 || bus.req_ready_1) && ng < 5) begin
                gseq[ng] = bus.req_ready_1;
                ng++;
            end
            if (bus.rsp_valid) begin
                rseq[nr] = bus.rsp_id;
                if (bus.rsp_data !== (bus.rsp_id ? 11'h222 : 11'h111)) ok = 0;
                nr++;
                if (nr == 5) begin
                    bus.req_valid_0 = 0;
                    bus.req_valid_1 = 0;
                end
            end
            tick();
        end
        chk("t2_grant_count", 32'(ng),   32'd5);
        chk("t2_rsp_count",   32'(nr),   32'd5);
        chk("t2_grant_seq",   32'(gseq), 32'h0A);
        chk("t2_rsp_id_seq",  32'(rseq), 32'h0A);
        chk("t2_dual_ready",  32'(both), 32'd0);
        chk("t2_rsp_data",    32'(ok),   32'd1);

        // Reset pulse during WAIT aborts the request and clears the round-robin pointer
        bus.req_valid_1 = 1; bus.req_data_1 = 11'h7E1;
        #1;
        chk("t5_ready1", 32'(bus.req_ready_1), 32'd1);
        tick(); bus.req_valid_1 = 0;
        tick();
        reset = 0;
        #1;
        chk("t5_dp_data",   32'(bus.dp_data),   32'd0);
        chk("t5_dp_poly",   32'(bus.dp_poly),   32'd0);
        chk("t5_dp_start",  32'(bus.dp_start),  32'd0);
        chk("t5_dp_err_en", 32'(bus.dp_err_en), 32'd0);
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_rsp_data",  32'(bus.rsp_data),  32'd0);
        tick();
        reset = 1;
        seen = 0;
        for (int c = 0; c < DP_LAT + 6; c++) begin
            if (bus.rsp_valid) seen = 1;
            tick();
        end
        chk("t5_no_rsp", 32'(seen), 32'd0);
        bus.req_valid_0 = 1; bus.req_valid_1 = 1;
        #1;
        chk("t5_grant0",    32'(bus.req_ready_0), 32'd1);
        chk("t5_no_grant1", 32'(bus.req_ready_1), 32'd0);
        tick(); bus.req_valid_0 = 0; bus.req_valid_1 = 0;
        wait_rsp("t5_rsp_timeout");
        chk("t5_rsp_id",   32'(bus.rsp_id),   32'd0);
        chk("t5_rsp_data", 32'(bus.rsp_data), 32'h111);
        tick();

`ifdef CRC_SCHED_STATS_EN
        // Counters cleared by the reset pulse, then 300 error responses on requester 1
        chk("t6_cnt1_cleared", 32'(err_cnt_1), 32'd0);
        bus.req_valid_1 = 1; bus.req_data_1 = 11'h0AA; bus.req_errinj_1 = 1;
        hs = 0;
        for (int c = 0; c < 4000 && hs < 300; c++) begin
            #1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                hs++;
                if (hs == 300) bus.req_valid_1 = 0;
            end
            tick();
        end
        tick();
        chk("t6_hs_count",  32'(hs),        32'd300);
        chk("t6_err_cnt_1", 32'(err_cnt_1), 32'd255);
        chk("t6_err_cnt_0", 32'(err_cnt_0), 32'd0);
`else
        hs = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
